// File: rtl/oam_dma_ctrl_if.sv
// CPU-side and memory-side bus bundle for the sprite DMA controller.
// The controller takes the master modport; the CPU/memory environment takes slave.
interface oam_dma_ctrl_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_r_nw;
  logic        cpu_rdy;
  logic [15:0] mem_addr;
  logic [7:0]  mem_dout;
  logic        mem_r_nw;
  logic [7:0]  mem_din;
  logic        dma_active;

  modport master (
    input  cpu_addr, cpu_dout, cpu_r_nw, mem_din,
    output cpu_rdy, mem_addr, mem_dout, mem_r_nw, dma_active
  );

  modport slave (
    output cpu_addr, cpu_dout, cpu_r_nw, mem_din,
    input  cpu_rdy, mem_addr, mem_dout, mem_r_nw, dma_active
  );
endinterface

// File: rtl/oam_dma_ctrl.sv
// Sprite (OAM) DMA sequencer: stalls the CPU and copies a 256-byte page to the
// OAM data port as read/write pairs, arbitrating the memory bus between the two.
module oam_dma_ctrl #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input  logic           clk_ph1,
  input  logic           rst,
  oam_dma_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    StIdle,
    StWaitRd,
    StHalt,
    StAlign,
    StRead,
    StWrite
  } state_e;

  state_e     state;
  logic [7:0] page;
  logic [7:0] idx;
  logic [7:0] data;
  logic       cycle_odd;
  logic       rdy;
  logic       active;

  always_ff @(posedge clk_ph1 or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      page      <= 8'h00;
      idx       <= 8'h00;
      data      <= 8'h00;
      cycle_odd <= 1'b0;
      rdy       <= 1'b1;
      active    <= 1'b0;
    end else begin
      cycle_odd <= ~cycle_odd;
      case (state)
        StIdle: begin
          if (!bus.cpu_r_nw && bus.cpu_addr == DMA_REG_ADDR) begin
            page  <= bus.cpu_dout;
            idx   <= 8'h00;
            state <= StWaitRd;
            rdy   <= 1'b0;
          end
        end
        // RDY only freezes reads, so pending CPU writes drain here first.
        StWaitRd: begin
          if (bus.cpu_r_nw) state <= StHalt;
        end
        StHalt: begin
          if (cycle_odd) begin
            state  <= StRead;
            active <= 1'b1;
          end else begin
            state <= StAlign;
          end
        end
        StAlign: begin
          state  <= StRead;
          active <= 1'b1;
        end
        StRead: begin
          data  <= bus.mem_din;
          state <= StWrite;
        end
        StWrite: begin
          idx <= idx + 8'd1;
          if (idx == 8'hFF) begin
            state  <= StIdle;
            rdy    <= 1'b1;
            active <= 1'b0;
          end else begin
            state <= StRead;
          end
        end
        default: begin
          state  <= StIdle;
          rdy    <= 1'b1;
          active <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cpu_rdy    = rdy;
  assign bus.dma_active = active;

  // Source address is {page, idx}; idx wraps without carrying into page.
  always_comb begin
    bus.mem_addr = bus.cpu_addr;
    bus.mem_dout = bus.cpu_dout;
    bus.mem_r_nw = bus.cpu_r_nw;
    if (state == StRead) begin
      bus.mem_addr = {page, idx};
      bus.mem_r_nw = 1'b1;
    end else if (state == StWrite) begin
      bus.mem_addr = OAM_DATA_ADDR;
      bus.mem_dout = data;
      bus.mem_r_nw = 1'b0;
    end
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl: reset, idle writes, even/odd triggers,
// write-draining before halt, page FF wrap and reset mid-transfer.
module tb_oam_dma_ctrl;

  logic clk;
  logic rst;
  logic mem_mode;
  int   cyc;
  int   nchk;
  int   nfail;

  oam_dma_ctrl_if bus ();

  oam_dma_ctrl dut (
    .clk_ph1 (clk),
    .rst     (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Mirrors the DUT's even/odd cycle numbering from reset.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  always_comb begin
    if (mem_mode) bus.mem_din = bus.mem_addr[7:0];
    else          bus.mem_din = (bus.mem_addr[7:0] ^ 8'hA5) + bus.mem_addr[15:8];
  end

  function automatic logic [7:0] mem_model(input logic md, input logic [15:0] a);
    if (md) return a[7:0];
    return (a[7:0] ^ 8'hA5) + a[15:8];
  endfunction

  task automatic cpu_drive(input logic [15:0] a, input logic [7:0] d, input logic rnw);
    bus.cpu_addr = a;
    bus.cpu_dout = d;
    bus.cpu_r_nw = rnw;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cpu_drive(16'h4014, 8'h5A, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    nchk++;
    if (bus.cpu_rdy !== 1'b1 || bus.dma_active !== 1'b0) begin
      nfail++;
      $display("FAIL reset_status: rdy=%b active=%b, expected rdy=1 active=0",
               bus.cpu_rdy, bus.dma_active);
    end
    nchk++;
    if (bus.mem_addr !== 16'h4014 || bus.mem_dout !== 8'h5A || bus.mem_r_nw !== 1'b0) begin
      nfail++;
      $display("FAIL reset_passthru: addr=%h dout=%h rnw=%b, expected 4014 5a 0",
               bus.mem_addr, bus.mem_dout, bus.mem_r_nw);
    end
    cpu_drive(16'h8000, 8'h00, 1'b1);
    #1;
    nchk++;
    if (bus.mem_addr !== 16'h8000 || bus.mem_r_nw !== 1'b1) begin
      nfail++;
      $display("FAIL reset_passthru_rd: addr=%h rnw=%b, expected 8000 1",
               bus.mem_addr, bus.mem_r_nw);
    end
    rst = 1'b0;
  endtask

  task automatic test_idle_writes();
    logic [15:0] addrs [2];
    int          bad;
    addrs[0] = 16'h4015;
    addrs[1] = 16'h2004;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      cpu_drive(addrs[i], 8'h33, 1'b0);
      @(negedge clk);
      nchk++;
      if (bus.cpu_rdy !== 1'b1 || bus.mem_addr !== addrs[i] || bus.mem_dout !== 8'h33 ||
          bus.mem_r_nw !== 1'b0) begin
        nfail++;
        $display("FAIL idle_write_%h: rdy=%b addr=%h dout=%h rnw=%b, expected 1 %h 33 0",
                 addrs[i], bus.cpu_rdy, bus.mem_addr, bus.mem_dout, bus.mem_r_nw, addrs[i]);
      end
      bad = 0;
      for (int c = 0; c < 4; c++) begin
        @(posedge clk); #1;
        cpu_drive(16'h8000, 8'h00, 1'b1);
        @(negedge clk);
        if (bus.cpu_rdy !== 1'b1 || bus.dma_active !== 1'b0) bad++;
      end
      nchk++;
      if (bad != 0) begin
        nfail++;
        $display("FAIL idle_no_dma_%h: %0d stalled cycles, expected 0", addrs[i], bad);
      end
    end
  endtask

  task automatic run_transfer(input string name, input logic [7:0] pg, input logic trig_odd,
                              input int n_push, input int exp_stall);
    int          stall, n_rd, n_wr, bad_addr, bad_data, odd_rd, first_rd, guard;
    logic [15:0] last_src;
    logic [15:0] push_addr;
    logic [7:0]  k;
    stall = 0; n_rd = 0; n_wr = 0; bad_addr = 0; bad_data = 0; odd_rd = 0;
    first_rd = -1; guard = 0; k = 8'h00; last_src = 16'h0000;

    do begin
      @(posedge clk); #1;
      guard++;
    end while (cyc[0] != trig_odd && guard < 4);
    cpu_drive(16'h4014, pg, 1'b0);
    @(negedge clk);
    nchk++;
    if (bus.cpu_rdy !== 1'b1 || bus.mem_addr !== 16'h4014 || bus.mem_dout !== pg ||
        bus.mem_r_nw !== 1'b0 || cyc[0] != trig_odd) begin
      nfail++;
      $display("FAIL %s_trigger: rdy=%b addr=%h dout=%h rnw=%b par=%0d, expected 1 4014 %h 0 %0d",
               name, bus.cpu_rdy, bus.mem_addr, bus.mem_dout, bus.mem_r_nw, cyc[0], pg,
               trig_odd);
    end

    for (int i = 0; i < n_push; i++) begin
      @(posedge clk); #1;
      push_addr = (i == 1) ? 16'h4014 : 16'(16'h01FD - i);
      cpu_drive(push_addr, 8'(8'h70 + i), 1'b0);
      @(negedge clk);
      nchk++;
      if (bus.cpu_rdy !== 1'b0 || bus.dma_active !== 1'b0 || bus.mem_addr !== push_addr ||
          bus.mem_dout !== 8'(8'h70 + i) || bus.mem_r_nw !== 1'b0) begin
        nfail++;
        $display("FAIL %s_push%0d: rdy=%b act=%b addr=%h dout=%h rnw=%b, expected 0 0 %h %h 0",
                 name, i, bus.cpu_rdy, bus.dma_active, bus.mem_addr, bus.mem_dout,
                 bus.mem_r_nw, push_addr, 8'(8'h70 + i));
      end
    end

    @(posedge clk); #1;
    cpu_drive(16'h8123, 8'hEE, 1'b1);
    for (int c = 0; c < 700; c++) begin
      @(negedge clk);
      if (bus.cpu_rdy === 1'b1) break;
      if (bus.dma_active === 1'b1) begin
        if (bus.mem_r_nw === 1'b1) begin
          if (first_rd < 0) first_rd = stall;
          if (bus.mem_addr !== {pg, k}) bad_addr++;
          if (cyc[0]) odd_rd++;
          last_src = bus.mem_addr;
          n_rd++;
        end else begin
          if (bus.mem_addr !== 16'h2004 || bus.mem_dout !== mem_model(mem_mode, {pg, k}))
            bad_data++;
          k++;
          n_wr++;
        end
      end else if (bus.mem_addr !== 16'h8123 || bus.mem_r_nw !== 1'b1) begin
        bad_addr++;
      end
      stall++;
    end

    nchk++;
    if (stall != exp_stall) begin
      nfail++;
      $display("FAIL %s_stall: got %0d cycles, expected %0d", name, stall, exp_stall);
    end
    nchk++;
    if (n_rd != 256 || n_wr != 256) begin
      nfail++;
      $display("FAIL %s_count: reads=%0d writes=%0d, expected 256 256", name, n_rd, n_wr);
    end
    nchk++;
    if (bad_addr != 0 || bad_data != 0) begin
      nfail++;
      $display("FAIL %s_bytes: bad_addr=%0d bad_data=%0d, expected 0 0", name, bad_addr,
               bad_data);
    end
    nchk++;
    if (odd_rd != 0 || first_rd != exp_stall - 512) begin
      nfail++;
      $display("FAIL %s_align: odd_reads=%0d first_read=%0d, expected 0 %0d", name, odd_rd,
               first_rd, exp_stall - 512);
    end
    nchk++;
    if (last_src !== {pg, 8'hFF} || bus.dma_active !== 1'b0 || bus.mem_addr !== 16'h8123) begin
      nfail++;
      $display("FAIL %s_end: last_src=%h act=%b addr=%h, expected %h 0 8123", name, last_src,
               bus.dma_active, bus.mem_addr, {pg, 8'hFF});
    end
    @(posedge clk); #1;
    cpu_drive(16'h8000, 8'h00, 1'b1);
  endtask

  task automatic test_even_trigger();
    mem_mode = 1'b0;
    run_transfer("even", 8'h02, 1'b0, 0, 515);
  endtask

  task automatic test_odd_trigger();
    mem_mode = 1'b0;
    run_transfer("odd", 8'h03, 1'b1, 0, 514);
  endtask

  task automatic test_brk_pushes();
    mem_mode = 1'b0;
    run_transfer("pushes", 8'h05, 1'b1, 3, 515);
  endtask

  task automatic test_page_ff();
    mem_mode = 1'b1;
    run_transfer("page_ff", 8'hFF, 1'b1, 0, 514);
  endtask

  task automatic test_reset_mid();
    int found;
    int bad;
    found = 0;
    mem_mode = 1'b0;
    @(posedge clk); #1;
    cpu_drive(16'h4014, 8'h06, 1'b0);
    @(posedge clk); #1;
    cpu_drive(16'h8123, 8'h00, 1'b1);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.dma_active === 1'b1 && bus.mem_r_nw === 1'b1) begin
        found = 1;
        break;
      end
    end
    nchk++;
    if (found == 0) begin
      nfail++;
      $display("FAIL mid_reach_read: no DMA read within 12 cycles, expected one");
    end
    #2 rst = 1'b1;
    #1;
    nchk++;
    if (bus.cpu_rdy !== 1'b1 || bus.dma_active !== 1'b0 || bus.mem_addr !== 16'h8123 ||
        bus.mem_r_nw !== 1'b1) begin
      nfail++;
      $display("FAIL mid_reset_immediate: rdy=%b act=%b addr=%h rnw=%b, expected 1 0 8123 1",
               bus.cpu_rdy, bus.dma_active, bus.mem_addr, bus.mem_r_nw);
    end
    #1 rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.cpu_rdy !== 1'b1 || bus.dma_active !== 1'b0 || bus.mem_addr !== 16'h8123) bad++;
    end
    nchk++;
    if (bad != 0) begin
      nfail++;
      $display("FAIL mid_reset_stays_idle: %0d bad cycles, expected 0", bad);
    end
  endtask

  initial begin
    nchk = 0;
    nfail = 0;
    mem_mode = 1'b0;
    rst = 1'b1;
    cpu_drive(16'h0000, 8'h00, 1'b1);
    test_reset();
    test_idle_writes();
    test_even_trigger();
    test_odd_trigger();
    test_brk_pushes();
    test_page_ff();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
